// File: rtl/arm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multi-cycle LEGv8 control sequencer.
//   - opcode match table (mask/match per instruction class)
//   - instruction class enum
//   - one-hot state codes
//   - ALU operation and fault codes driven onto the datapath
// ----------------------------------------------------------------------------
package arm_ctrl_pkg;

  localparam int OPC_W = 11;   // IR[31:21]
  localparam int N_CLS = 5;    // number of recognised instruction classes
  localparam int ST_W  = 6;    // one-hot state width

  // Class codes double as the row index into the match table below,
  // so the decoder can turn a table hit straight into a class code.
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LDUR = 3'd1,
    CLS_STUR = 3'd2,
    CLS_CBZ  = 3'd3,
    CLS_B    = 3'd4
  } instr_cls_e;

  // Row i matches when (opcode & OPC_MASK[i]) == OPC_MATCH[i].
  // Packed concatenation lists the highest row first.
  //   row 4  B         000101xxxxx
  //   row 3  CBZ       10110100xxx
  //   row 2  STUR      11111000000
  //   row 1  LDUR      11111000010
  //   row 0  R-type    1xx0101x000  (ADD/SUB/AND/ORR)
  localparam logic [N_CLS-1:0][OPC_W-1:0] OPC_MASK = {
    11'b11111100000,
    11'b11111111000,
    11'b11111111111,
    11'b11111111111,
    11'b10011110111
  };
  localparam logic [N_CLS-1:0][OPC_W-1:0] OPC_MATCH = {
    11'b00010100000,
    11'b10110100000,
    11'b11111000000,
    11'b11111000010,
    11'b10001010000
  };

  // One-hot sequencer states
  localparam logic [ST_W-1:0] ST_FETCH  = 6'b000001;
  localparam logic [ST_W-1:0] ST_DECODE = 6'b000010;
  localparam logic [ST_W-1:0] ST_EXEC   = 6'b000100;
  localparam logic [ST_W-1:0] ST_MEM    = 6'b001000;
  localparam logic [ST_W-1:0] ST_WB     = 6'b010000;
  localparam logic [ST_W-1:0] ST_HALT   = 6'b100000;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASS  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Fault codes reported while halted
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM    = 2'b10;
  localparam logic [1:0] FAULT_DMEM    = 2'b11;

endpackage

// File: rtl/opcode_class.sv
// ----------------------------------------------------------------------------
// opcode_class
// Purely combinational opcode classifier for the LEGv8 sequencer.
// Ports:
//   opcode   in   11  IR[31:21]
//   cls      out  3   instruction class (instr_cls_e encoding)
//   illegal  out  1   opcode matches no known class
// ----------------------------------------------------------------------------
module opcode_class
  import arm_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [2:0]       cls,
  output logic             illegal
);

  logic [N_CLS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLS; gi++) begin : g_match
      assign hit[gi] = ((opcode & OPC_MASK[gi]) == OPC_MATCH[gi]);
    end
  endgenerate

  // The table rows are mutually exclusive, so the scan order only matters
  // for readability; the lowest hitting row wins.
  always_comb begin
    cls     = CLS_R;
    illegal = (hit == '0);
    for (int i = N_CLS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        cls = 3'(i);
      end
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle LEGv8 sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath strobes.
// Waits on imem/dmem ready handshakes and halts on an illegal opcode or
// a memory timeout.
// Parameters:
//   WAIT_MAX  cycles to wait for a ready before timing out (0 = never)
//   CNT_W     wait counter width, 2**CNT_W > WAIT_MAX
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   opcode[10:0]                   IR[31:21], valid from DECODE onward
//   imem_ready, dmem_ready         memory handshakes
//   imem_read, ir_write, pc_write  fetch / IR / PC strobes
//   reg2_loc, uncondbranch, branch register-2 select and branch strobes
//   mem_read, mem_write, mem_to_reg data memory strobes
//   alu_op[1:0], alu_src           ALU control
//   reg_write                      regfile write enable
//   instr_done                     one-cycle retire pulse
//   halted, fault[1:0]             sticky halt flag and its cause
// ----------------------------------------------------------------------------
module multicycle_control
  import arm_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_read,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg2_loc,
  output logic        uncondbranch,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        reg_write,
  output logic        instr_done,
  output logic        halted,
  output logic [1:0]  fault
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ST_W-1:0]  state_reg,    state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]       fault_reg,    fault_next;
  instr_cls_e       cls_reg,      cls_next;

  // --------------------------------------------------------------------------
  // Opcode classification (only consumed in DECODE). The class is all the
  // sequencer needs afterwards, so the raw opcode is not kept.
  // --------------------------------------------------------------------------
  logic [2:0] dec_cls;
  logic       dec_illegal;

  opcode_class u_opcode_class (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // --------------------------------------------------------------------------
  // Timeout detect: true on the last permitted wait cycle. With WAIT_MAX=0
  // the counter still runs (and wraps) but never triggers a timeout.
  // --------------------------------------------------------------------------
  logic wait_last;

  generate
    if (WAIT_MAX == 0) begin : g_no_timeout
      assign wait_last = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
      assign wait_last = (wait_cnt_reg == WAIT_LAST);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
      fault_reg    <= FAULT_NONE;
      cls_reg      <= CLS_R;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= fault_next;
      cls_reg      <= cls_next;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    fault_next    = fault_reg;
    cls_next      = cls_reg;

    case (state_reg)
      ST_FETCH: begin
        // A ready on the timeout cycle still completes the fetch.
        if (imem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_last) begin
          state_next = ST_HALT;
          fault_next = FAULT_IMEM;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end

      ST_DECODE: begin
        if (dec_illegal) begin
          state_next = ST_HALT;
          fault_next = FAULT_ILLEGAL;
        end else begin
          cls_next   = instr_cls_e'(dec_cls);
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_reg)
          CLS_R:              state_next = ST_WB;
          CLS_LDUR, CLS_STUR: state_next = ST_MEM;
          default:            state_next = ST_FETCH;  // CBZ / B retire here
        endcase
      end

      ST_MEM: begin
        if (dmem_ready) begin
          state_next = (cls_reg == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (wait_last) begin
          state_next = ST_HALT;
          fault_next = FAULT_DMEM;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end

      ST_WB: begin
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        // Corrupted one-hot code: park safely and flag it.
        state_next = ST_HALT;
        fault_next = FAULT_ILLEGAL;
      end
    endcase

    // The wait counter measures time spent in the current state only.
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Process 3: output decode. Strobes follow state and class; the fetch and
  // store-retire strobes additionally qualify on their ready handshake.
  // Everything is forced low while reset is asserted so an aborted
  // instruction cannot disturb the datapath in the reset cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    imem_read    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg2_loc     = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = ALU_OP_ADD;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    fault        = FAULT_NONE;

    if (!reset) begin
      fault = fault_reg;
      case (state_reg)
        ST_FETCH: begin
          imem_read = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end

        ST_EXEC: begin
          case (cls_reg)
            CLS_R: begin
              alu_op = ALU_OP_FUNCT;
            end
            CLS_LDUR, CLS_STUR: begin
              alu_src = 1'b1;
              alu_op  = ALU_OP_ADD;
            end
            CLS_CBZ: begin
              reg2_loc   = 1'b1;
              alu_op     = ALU_OP_PASS;
              branch     = 1'b1;
              pc_write   = 1'b1;
              instr_done = 1'b1;
            end
            CLS_B: begin
              uncondbranch = 1'b1;
              pc_write     = 1'b1;
              instr_done   = 1'b1;
            end
            default: ;
          endcase
        end

        ST_MEM: begin
          // Address generation stays stable for the whole memory access.
          alu_src = 1'b1;
          alu_op  = ALU_OP_ADD;
          if (cls_reg == CLS_LDUR) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
            reg2_loc  = 1'b1;   // store data comes from Rt
            if (dmem_ready) begin
              instr_done = 1'b1;
            end
          end
        end

        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_reg == CLS_LDUR);
          instr_done = 1'b1;
        end

        ST_HALT: begin
          halted = 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Table-driven check of the multi-cycle sequencer: each table row is one
// clock cycle of inputs plus the expected strobe vector, followed by
// hand-written sequences for the timeout corner cases.
// Output vector layout (17 bits):
//   16 imem_read 15 ir_write 14 pc_write 13 reg2_loc 12 uncondbranch
//   11 branch 10 mem_read 9 mem_write 8 mem_to_reg 7:6 alu_op 5 alu_src
//   4 reg_write 3 instr_done 2 halted 1:0 fault
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [16:0] O_NONE  = 17'h00000;
  localparam logic [16:0] O_IMR   = 17'h10000;
  localparam logic [16:0] O_IRW   = 17'h08000;
  localparam logic [16:0] O_PCW   = 17'h04000;
  localparam logic [16:0] O_R2L   = 17'h02000;
  localparam logic [16:0] O_UB    = 17'h01000;
  localparam logic [16:0] O_BR    = 17'h00800;
  localparam logic [16:0] O_MR    = 17'h00400;
  localparam logic [16:0] O_MW    = 17'h00200;
  localparam logic [16:0] O_M2R   = 17'h00100;
  localparam logic [16:0] O_FUNCT = 17'h00080;
  localparam logic [16:0] O_PASS  = 17'h00040;
  localparam logic [16:0] O_ASRC  = 17'h00020;
  localparam logic [16:0] O_RW    = 17'h00010;
  localparam logic [16:0] O_DONE  = 17'h00008;
  localparam logic [16:0] O_HALT  = 17'h00004;
  localparam logic [16:0] O_F_ILL = 17'h00001;
  localparam logic [16:0] O_F_IM  = 17'h00002;
  localparam logic [16:0] O_F_DM  = 17'h00003;

  localparam logic [16:0] O_FETCH_OK = O_IMR | O_IRW | O_PCW;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] opcode = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_ready0 = 1'b0;

  logic imem_read, ir_write, pc_write, reg2_loc, uncondbranch, branch;
  logic mem_read, mem_write, mem_to_reg, alu_src, reg_write, instr_done, halted;
  logic [1:0] alu_op, fault;

  logic imem_read0, ir_write0, pc_write0, reg2_loc0, uncondbranch0, branch0;
  logic mem_read0, mem_write0, mem_to_reg0, alu_src0, reg_write0, instr_done0, halted0;
  logic [1:0] alu_op0, fault0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write),
    .reg2_loc(reg2_loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .instr_done(instr_done), .halted(halted), .fault(fault)
  );

  // Same sequencer with the timeout disabled; its fetch never gets a ready.
  multicycle_control #(.WAIT_MAX(0), .CNT_W(5)) dut_nto (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ready(imem_ready0), .dmem_ready(dmem_ready),
    .imem_read(imem_read0), .ir_write(ir_write0), .pc_write(pc_write0),
    .reg2_loc(reg2_loc0), .uncondbranch(uncondbranch0), .branch(branch0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_to_reg(mem_to_reg0),
    .alu_op(alu_op0), .alu_src(alu_src0), .reg_write(reg_write0),
    .instr_done(instr_done0), .halted(halted0), .fault(fault0)
  );

  logic [16:0] out_vec, out_vec0;
  assign out_vec  = {imem_read, ir_write, pc_write, reg2_loc, uncondbranch, branch,
                     mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write,
                     instr_done, halted, fault};
  assign out_vec0 = {imem_read0, ir_write0, pc_write0, reg2_loc0, uncondbranch0, branch0,
                     mem_read0, mem_write0, mem_to_reg0, alu_op0, alu_src0, reg_write0,
                     instr_done0, halted0, fault0};

  typedef struct {
    logic        rst;
    logic [10:0] opc;
    logic        ir;
    logic        dr;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic [10:0] opc, input logic ir,
                     input logic dr, input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.opc = opc; v.ir = ir; v.dr = dr; v.exp = exp;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive inputs just after the rising edge, sample at the
  // falling edge.
  task automatic step(input logic rst, input logic [10:0] opc, input logic ir, input logic dr);
    @(posedge clk);
    #1;
    reset      = rst;
    opcode     = opc;
    imem_ready = ir;
    dmem_ready = dr;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end else begin
      $display("ok   %s: out=%05h", name, act);
    end
  endtask

  initial begin
    // ---------------- table ----------------
    add(1, OP_ADD, 1, 1, O_NONE);                          // reset state
    // ADD, 4 cycles
    add(0, OP_ADD, 1, 1, O_FETCH_OK);
    add(0, OP_ADD, 1, 1, O_NONE);
    add(0, OP_ADD, 1, 1, O_FUNCT);
    add(0, OP_ADD, 1, 1, O_RW | O_DONE);
    // LDUR, dmem ready after 3 wait cycles
    add(0, OP_LDUR, 1, 0, O_FETCH_OK);
    add(0, OP_LDUR, 1, 0, O_NONE);
    add(0, OP_LDUR, 1, 0, O_ASRC);
    add(0, OP_LDUR, 1, 0, O_ASRC | O_MR);
    add(0, OP_LDUR, 1, 0, O_ASRC | O_MR);
    add(0, OP_LDUR, 1, 0, O_ASRC | O_MR);
    add(0, OP_LDUR, 1, 1, O_ASRC | O_MR);
    add(0, OP_LDUR, 1, 1, O_RW | O_M2R | O_DONE);
    // CBZ, 3 cycles
    add(0, OP_CBZ, 1, 1, O_FETCH_OK);
    add(0, OP_CBZ, 1, 1, O_NONE);
    add(0, OP_CBZ, 1, 1, O_R2L | O_PASS | O_BR | O_PCW | O_DONE);
    // B, with two fetch wait cycles first
    add(0, OP_B, 0, 1, O_IMR);
    add(0, OP_B, 0, 1, O_IMR);
    add(0, OP_B, 1, 1, O_FETCH_OK);
    add(0, OP_B, 1, 1, O_NONE);
    add(0, OP_B, 1, 1, O_UB | O_PCW | O_DONE);
    // STUR, 4 cycles
    add(0, OP_STUR, 1, 1, O_FETCH_OK);
    add(0, OP_STUR, 1, 1, O_NONE);
    add(0, OP_STUR, 1, 1, O_ASRC);
    add(0, OP_STUR, 1, 1, O_ASRC | O_MW | O_R2L | O_DONE);
    // Illegal opcode: sticky halt, ready ignored, reset recovers
    add(0, OP_BAD, 1, 1, O_FETCH_OK);
    add(0, OP_BAD, 1, 1, O_NONE);
    add(0, OP_BAD, 1, 1, O_HALT | O_F_ILL);
    add(0, OP_BAD, 1, 1, O_HALT | O_F_ILL);
    add(1, OP_BAD, 1, 1, O_NONE);
    add(0, OP_ADD, 0, 0, O_IMR);
    // STUR aborted by reset in MEM
    add(0, OP_STUR, 1, 0, O_FETCH_OK);
    add(0, OP_STUR, 1, 0, O_NONE);
    add(0, OP_STUR, 1, 0, O_ASRC);
    add(0, OP_STUR, 1, 0, O_ASRC | O_MW | O_R2L);
    add(1, OP_STUR, 1, 0, O_NONE);
    add(0, OP_STUR, 0, 0, O_IMR);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].opc, tbl[i].ir, tbl[i].dr);
      check($sformatf("vec%0d", i), out_vec, tbl[i].exp);
    end

    // ---------------- imem timeout (and no-timeout instance) ----------------
    step(1, OP_ADD, 0, 0);
    check("imem_to_rst", out_vec, O_NONE);
    for (int i = 0; i < 16; i++) begin
      step(0, OP_ADD, 0, 0);
      check($sformatf("imem_wait%0d", i), out_vec, O_IMR);
    end
    for (int i = 0; i < 24; i++) begin
      step(0, OP_ADD, 0, 0);
      check($sformatf("imem_halt%0d", i), out_vec, O_HALT | O_F_IM);
      check($sformatf("nto_fetch%0d", i), out_vec0, O_IMR);
    end

    // ---------------- ready on the timeout cycle wins ----------------
    step(1, OP_ADD, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, OP_ADD, 0, 0);
    end
    check("imem_last_wait", out_vec, O_IMR);
    step(0, OP_ADD, 1, 0);
    check("imem_late_ready", out_vec, O_FETCH_OK);
    step(0, OP_ADD, 0, 0);
    check("late_decode", out_vec, O_NONE);
    step(0, OP_ADD, 0, 0);
    check("late_exec", out_vec, O_FUNCT);

    // ---------------- dmem timeout ----------------
    step(1, OP_LDUR, 1, 0);
    step(0, OP_LDUR, 1, 0);
    check("dm_fetch", out_vec, O_FETCH_OK);
    step(0, OP_LDUR, 0, 0);
    step(0, OP_LDUR, 0, 0);
    check("dm_exec", out_vec, O_ASRC);
    for (int i = 0; i < 16; i++) begin
      step(0, OP_LDUR, 0, 0);
    end
    check("dm_last_wait", out_vec, O_ASRC | O_MR);
    step(0, OP_LDUR, 0, 1);
    check("dm_halt", out_vec, O_HALT | O_F_DM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
